hazard_scheduler: RTL and testbench

Issue controller for the 8-bit RISC-V pipeline's decode stage. It tracks the destination registers of instructions issued from decode that have not yet written back, in a small shift-register scoreboard. On a read-after-write hazard it holds PC and IF/ID and injects bubbles into ID/EX. When EX reports a taken branch it squashes the wrong-path instructions. The pipeline has no forwarding, so this block alone guarantees that decode reads committed register values.

---
 rtl/hazard_scheduler_if.sv | 29 ++
 rtl/hazard_scheduler.sv | 168 ++++++++++++++++
 tb/tb_hazard_scheduler.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_scheduler_if.sv
// Decode-stage issue bundle: the IF/ID view in, pipeline enables and debug counters out.
// The master side is the pipeline (or bench); the slave side is the scheduler.
interface hazard_scheduler_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      instruction;
  logic             if_valid;
  logic             branch_taken;
  logic             pc_write_en;
  logic             ifid_write_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             stall;
  logic [31:0]      busy_regs;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output instruction, if_valid, branch_taken,
    input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble, stall,
           busy_regs, stall_count, flush_count
  );

  modport slave (
    input  instruction, if_valid, branch_taken,
    output pc_write_en, ifid_write_en, ifid_flush, idex_bubble, stall,
           busy_regs, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Decode-stage issue controller: RAW interlock via a shift-register scoreboard of
// in-flight destinations, plus wrong-path squash after a taken branch.
module hazard_scheduler #(
  parameter int DEPTH     = 3,
  parameter int FLUSH_LEN = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  hazard_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [2:0]              r_flushCnt;
  logic [2:0]              w_flushCntNext;
  logic [DEPTH-1:0]        r_slotValid;
  logic [DEPTH-1:0][4:0]   r_slotRd;
  logic [CNT_W-1:0]        r_stallCount;
  logic [CNT_W-1:0]        r_flushCount;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_writesRd;
  logic        w_usesRs1;
  logic        w_usesRs2;
  logic        w_rs1Busy;
  logic        w_rs2Busy;
  logic        w_hazard;
  logic [31:0] w_busyRegs;
  logic        w_issue;
  logic        w_slot0Valid;
  logic [4:0]  w_slot0Rd;
  logic        w_pcWriteEn;
  logic        w_ifidWriteEn;
  logic        w_ifidFlush;
  logic        w_idexBubble;
  logic        w_stall;

  assign w_opcode = bus.instruction[6:0];
  assign w_rd     = bus.instruction[11:7];
  assign w_rs1    = bus.instruction[19:15];
  assign w_rs2    = bus.instruction[24:20];

  always_comb begin
    w_writesRd = 1'b0;
    w_usesRs1  = 1'b0;
    w_usesRs2  = 1'b0;
    unique case (w_opcode)
      7'b0110011: begin w_writesRd = 1'b1; w_usesRs1 = 1'b1; w_usesRs2 = 1'b1; end
      7'b0010011: begin w_writesRd = 1'b1; w_usesRs1 = 1'b1; end
      7'b0000011: begin w_writesRd = 1'b1; w_usesRs1 = 1'b1; end
      7'b0100011: begin w_usesRs1 = 1'b1; w_usesRs2 = 1'b1; end
      7'b1100011: begin w_usesRs1 = 1'b1; w_usesRs2 = 1'b1; end
      default:    ;
    endcase
  end

  // Valid slots never hold x0, so a match against rs=0 is impossible by construction.
  always_comb begin
    w_rs1Busy  = 1'b0;
    w_rs2Busy  = 1'b0;
    w_busyRegs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_slotValid[i]) begin
        if (r_slotRd[i] == w_rs1) w_rs1Busy = 1'b1;
        if (r_slotRd[i] == w_rs2) w_rs2Busy = 1'b1;
        w_busyRegs[r_slotRd[i]] = 1'b1;
      end
    end
  end

  assign w_hazard = bus.if_valid &&
                    ((w_usesRs1 && (w_rs1 != 5'd0) && w_rs1Busy) ||
                     (w_usesRs2 && (w_rs2 != 5'd0) && w_rs2Busy));

  always_comb begin
    w_stateNext    = r_state;
    w_flushCntNext = r_flushCnt;
    w_pcWriteEn    = 1'b1;
    w_ifidWriteEn  = 1'b1;
    w_ifidFlush    = 1'b0;
    w_idexBubble   = 1'b0;
    w_stall        = 1'b0;
    w_issue        = 1'b0;
    if (bus.branch_taken) begin
      w_stateNext    = ST_FLUSH;
      w_flushCntNext = 3'(FLUSH_LEN);
      w_ifidFlush    = 1'b1;
      w_idexBubble   = 1'b1;
    end else if (r_state == ST_FLUSH) begin
      w_ifidFlush    = 1'b1;
      w_idexBubble   = 1'b1;
      w_flushCntNext = r_flushCnt - 3'd1;
      if (r_flushCnt <= 3'd1) begin
        w_stateNext    = ST_RUN;
        w_flushCntNext = 3'd0;
      end
    end else if (w_hazard) begin
      w_stateNext   = ST_STALL;
      w_pcWriteEn   = 1'b0;
      w_ifidWriteEn = 1'b0;
      w_idexBubble  = 1'b1;
      w_stall       = 1'b1;
    end else begin
      w_stateNext = ST_RUN;
      w_issue     = bus.if_valid;
    end
  end

  assign w_slot0Valid = w_issue && w_writesRd && (w_rd != 5'd0);
  assign w_slot0Rd    = w_issue ? w_rd : 5'd0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_RUN;
      r_flushCnt <= 3'd0;
    end else begin
      r_state    <= w_stateNext;
      r_flushCnt <= w_flushCntNext;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_slotValid <= '0;
      r_slotRd    <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        r_slotValid[i] <= r_slotValid[i-1];
        r_slotRd[i]    <= r_slotRd[i-1];
      end
      r_slotValid[0] <= w_slot0Valid;
      r_slotRd[0]    <= w_slot0Rd;
    end
  end

  // Performance counters stick at all-ones instead of wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stallCount <= '0;
      r_flushCount <= '0;
    end else begin
      if (w_stall && (r_stallCount != '1))
        r_stallCount <= r_stallCount + CNT_W'(1);
      if (bus.branch_taken && (r_flushCount != '1))
        r_flushCount <= r_flushCount + CNT_W'(1);
    end
  end

  assign bus.pc_write_en   = w_pcWriteEn;
  assign bus.ifid_write_en = w_ifidWriteEn;
  assign bus.ifid_flush    = w_ifidFlush;
  assign bus.idex_bubble   = w_idexBubble;
  assign bus.stall         = w_stall;
  assign bus.busy_regs     = w_busyRegs;
  assign bus.stall_count   = r_stallCount;
  assign bus.flush_count   = r_flushCount;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: RAW stalls, x0/independent issue, store rs2 use,
// branch squash during a stall, counter saturation (CNT_W=4) and async reset mid-stall.
module tb_hazard_scheduler;

  localparam int CNT_W = 4;

  localparam logic [31:0] ADDI_X5     = 32'h00100293;
  localparam logic [31:0] ADD_X6_X5   = 32'h00528333;
  localparam logic [31:0] ADD_X5_X5   = 32'h005282B3;
  localparam logic [31:0] ADD_X7_X0X1 = 32'h001003B3;
  localparam logic [31:0] ADDI_X3     = 32'h00100193;
  localparam logic [31:0] SW_X3_X4    = 32'h00322023;
  localparam logic [31:0] ADDI_X8_X1  = 32'h00308413;

  logic clock;
  logic reset_n;
  int   checkCount;
  int   errorCount;

  hazard_scheduler_if #(.CNT_W(CNT_W)) bus ();

  hazard_scheduler #(
    .DEPTH     (3),
    .FLUSH_LEN (1),
    .CNT_W     (CNT_W)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Every comparison funnels through here so counts stay consistent.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive the IF/ID view for one cycle and wait to the falling edge to observe.
  task automatic applyStimulus(input logic [31:0] instr, input logic valid, input logic branch);
    bus.instruction  = instr;
    bus.if_valid     = valid;
    bus.branch_taken = branch;
    @(negedge clock);
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset(input string tag);
    bus.instruction  = 32'h0;
    bus.if_valid     = 1'b0;
    bus.branch_taken = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #2;
    checkOutput({tag, "_rst_busy"}, bus.busy_regs, 32'h0);
    checkOutput({tag, "_rst_stall"}, {31'b0, bus.stall}, 32'h0);
    checkOutput({tag, "_rst_pcwe"}, {31'b0, bus.pc_write_en}, 32'h1);
    @(negedge clock);
    reset_n = 1'b1;
    advance();
  endtask

  initial begin
    checkCount       = 0;
    errorCount       = 0;
    reset_n          = 1'b0;
    bus.instruction  = 32'h0;
    bus.if_valid     = 1'b0;
    bus.branch_taken = 1'b0;
    #1;
    checkOutput("init_ifidwe", {31'b0, bus.ifid_write_en}, 32'h1);
    checkOutput("init_flush", {31'b0, bus.ifid_flush}, 32'h0);
    checkOutput("init_bubble", {31'b0, bus.idex_bubble}, 32'h0);
    checkOutput("init_stallcnt", 32'(bus.stall_count), 32'h0);
    checkOutput("init_flushcnt", 32'(bus.flush_count), 32'h0);

    doReset("dep");
    applyStimulus(ADDI_X5, 1'b1, 1'b0);
    checkOutput("dep_producer_stall", {31'b0, bus.stall}, 32'h0);
    advance();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ADD_X6_X5, 1'b1, 1'b0);
      checkOutput($sformatf("dep_stall_%0d", i), {31'b0, bus.stall}, 32'h1);
      checkOutput($sformatf("dep_pcwe_%0d", i), {31'b0, bus.pc_write_en}, 32'h0);
      checkOutput($sformatf("dep_bubble_%0d", i), {31'b0, bus.idex_bubble}, 32'h1);
      advance();
    end
    applyStimulus(ADD_X6_X5, 1'b1, 1'b0);
    checkOutput("dep_issue_stall", {31'b0, bus.stall}, 32'h0);
    checkOutput("dep_issue_pcwe", {31'b0, bus.pc_write_en}, 32'h1);
    checkOutput("dep_stallcnt", 32'(bus.stall_count), 32'd3);
    advance();
    applyStimulus(32'h0, 1'b0, 1'b0);
    checkOutput("dep_busy_x6", bus.busy_regs, 32'h0000_0040);
    advance();

    doReset("indep");
    applyStimulus(ADDI_X5, 1'b1, 1'b0);
    advance();
    applyStimulus(ADD_X7_X0X1, 1'b1, 1'b0);
    checkOutput("indep_busy", bus.busy_regs, 32'h0000_0020);
    checkOutput("indep_stall", {31'b0, bus.stall}, 32'h0);
    advance();
    applyStimulus(32'h0, 1'b0, 1'b0);
    checkOutput("indep_busy2", bus.busy_regs, 32'h0000_00A0);
    advance();

    doReset("store");
    applyStimulus(ADDI_X3, 1'b1, 1'b0);
    advance();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(SW_X3_X4, 1'b1, 1'b0);
      checkOutput($sformatf("store_stall_%0d", i), {31'b0, bus.stall}, 32'h1);
      advance();
    end
    applyStimulus(SW_X3_X4, 1'b1, 1'b0);
    checkOutput("store_issue", {31'b0, bus.stall}, 32'h0);
    advance();
    applyStimulus(32'h0, 1'b0, 1'b0);
    checkOutput("store_busy_none", bus.busy_regs, 32'h0);
    advance();

    doReset("itype");
    applyStimulus(ADDI_X3, 1'b1, 1'b0);
    advance();
    applyStimulus(ADDI_X8_X1, 1'b1, 1'b0);
    checkOutput("itype_imm_nostall", {31'b0, bus.stall}, 32'h0);
    advance();

    doReset("branch");
    applyStimulus(ADDI_X5, 1'b1, 1'b0);
    advance();
    applyStimulus(ADD_X6_X5, 1'b1, 1'b0);
    checkOutput("branch_first_stall", {31'b0, bus.stall}, 32'h1);
    advance();
    applyStimulus(ADD_X6_X5, 1'b1, 1'b1);
    checkOutput("branch_stall", {31'b0, bus.stall}, 32'h0);
    checkOutput("branch_flush", {31'b0, bus.ifid_flush}, 32'h1);
    checkOutput("branch_bubble", {31'b0, bus.idex_bubble}, 32'h1);
    checkOutput("branch_pcwe", {31'b0, bus.pc_write_en}, 32'h1);
    advance();
    applyStimulus(32'h0, 1'b0, 1'b0);
    checkOutput("branch_flushcnt", 32'(bus.flush_count), 32'd1);
    advance();
    applyStimulus(32'h0, 1'b0, 1'b0);
    checkOutput("branch_run_flush", {31'b0, bus.ifid_flush}, 32'h0);
    checkOutput("branch_run_bubble", {31'b0, bus.idex_bubble}, 32'h0);
    checkOutput("branch_stallcnt", 32'(bus.stall_count), 32'd1);
    checkOutput("branch_flushcnt2", 32'(bus.flush_count), 32'd1);
    advance();

    // add x5,x5,x5 held in IF/ID: 3 stalls then an issue, repeating; 28 cycles give 21 stalls.
    doReset("sat");
    applyStimulus(ADDI_X5, 1'b1, 1'b0);
    advance();
    for (int i = 0; i < 28; i++) begin
      applyStimulus(ADD_X5_X5, 1'b1, 1'b0);
      if (i == 12) checkOutput("sat_midcount", 32'(bus.stall_count), 32'd9);
      advance();
    end
    applyStimulus(32'h0, 1'b0, 1'b0);
    checkOutput("sat_stallcnt", 32'(bus.stall_count), 32'd15);
    advance();

    doReset("arst");
    applyStimulus(ADDI_X5, 1'b1, 1'b0);
    advance();
    applyStimulus(ADD_X6_X5, 1'b1, 1'b0);
    checkOutput("arst_pre_stall", {31'b0, bus.stall}, 32'h1);
    reset_n = 1'b0;
    #1;
    checkOutput("arst_busy", bus.busy_regs, 32'h0);
    checkOutput("arst_stall", {31'b0, bus.stall}, 32'h0);
    checkOutput("arst_stallcnt", 32'(bus.stall_count), 32'h0);
    #1;
    reset_n = 1'b1;
    advance();
    applyStimulus(ADD_X6_X5, 1'b1, 1'b0);
    checkOutput("arst_next_issue", {31'b0, bus.stall}, 32'h0);
    checkOutput("arst_next_pcwe", {31'b0, bus.pc_write_en}, 32'h1);
    advance();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
